// File: rtl/mux_8to1_if.sv
// Bus interface for the registered 8-to-1 multiplexer.
// Groups the capture enable, the eight data lanes, the select code and the
// registered result with its valid flag. The master side drives lanes and
// select; the slave side (the mux) returns Y and y_valid.
interface mux_8to1_if #(
   parameter int WIDTH = 1
);
   logic             en;
   logic [WIDTH-1:0] D0;
   logic [WIDTH-1:0] D1;
   logic [WIDTH-1:0] D2;
   logic [WIDTH-1:0] D3;
   logic [WIDTH-1:0] D4;
   logic [WIDTH-1:0] D5;
   logic [WIDTH-1:0] D6;
   logic [WIDTH-1:0] D7;
   logic [2:0]       Sel;
   logic [WIDTH-1:0] Y;
   logic             y_valid;

   modport master (
      output en, D0, D1, D2, D3, D4, D5, D6, D7, Sel,
      input  Y, y_valid
   );

   modport slave (
      input  en, D0, D1, D2, D3, D4, D5, D6, D7, Sel,
      output Y, y_valid
   );
endinterface

// File: rtl/mux_8to1.sv
// Registered 8-to-1 multiplexer.
// Y takes D[Sel] on an enabled rising clock edge; y_valid marks that Y holds
// a real capture rather than reset contents. When en is low every register
// holds, so a stall never drops or duplicates a selection.
// Build option: define MUX8_1_INPUT_PIPE_EN to add an input register stage
// (lanes, select and a valid bit) ahead of the mux, giving 2-cycle latency.
// Without it the mux reads the live inputs and latency is 1 cycle.
module mux_8to1 #(
   parameter int WIDTH = 1
) (
   input logic       clk,
   input logic       rst_n,
   mux_8to1_if.slave bus
);

   logic [WIDTH-1:0] liveD [8];
   logic [WIDTH-1:0] srcD [8];
   logic [2:0]       srcSel;
   logic             srcValid;
   logic [WIDTH-1:0] muxOut;
   logic [WIDTH-1:0] yReg;
   logic             validReg;

   assign liveD[0] = bus.D0;
   assign liveD[1] = bus.D1;
   assign liveD[2] = bus.D2;
   assign liveD[3] = bus.D3;
   assign liveD[4] = bus.D4;
   assign liveD[5] = bus.D5;
   assign liveD[6] = bus.D6;
   assign liveD[7] = bus.D7;

`ifdef MUX8_1_INPUT_PIPE_EN
   logic [WIDTH-1:0] stageD [8];
   logic [2:0]       stageSel;
   logic             stageValid;

   // Input stage: lanes and select are captured together so a select is
   // never paired with data from a different edge; the valid bit travels
   // alongside so y_valid follows the same two-cycle path as the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            stageD[i] <= '0;
         end
         stageSel   <= 3'd0;
         stageValid <= 1'b0;
      end else if (bus.en) begin
         for (int i = 0; i < 8; i++) begin
            stageD[i] <= liveD[i];
         end
         stageSel   <= bus.Sel;
         stageValid <= 1'b1;
      end
   end

   // The mux reads the registered copies, so its source is the stage.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         srcD[i] = stageD[i];
      end
      srcSel   = stageSel;
      srcValid = stageValid;
   end
`else
   // The mux reads the live lanes; any enabled capture is real data.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         srcD[i] = liveD[i];
      end
      srcSel   = bus.Sel;
      srcValid = 1'b1;
   end
`endif

   // Plain unsigned selection, all eight codes are legal lanes.
   always_comb begin
      muxOut = '0;
      case (srcSel)
         3'd0: muxOut = srcD[0];
         3'd1: muxOut = srcD[1];
         3'd2: muxOut = srcD[2];
         3'd3: muxOut = srcD[3];
         3'd4: muxOut = srcD[4];
         3'd5: muxOut = srcD[5];
         3'd6: muxOut = srcD[6];
         3'd7: muxOut = srcD[7];
         default: muxOut = '0;
      endcase
   end

   // Output register: Y only moves on an enabled edge or at reset, which
   // keeps the delivered lane glitch-free for downstream logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yReg     <= '0;
         validReg <= 1'b0;
      end else if (bus.en) begin
         yReg     <= muxOut;
         validReg <= srcValid;
      end
   end

   assign bus.Y       = yReg;
   assign bus.y_valid = validReg;

endmodule

// File: tb/tb_mux_8to1.sv
// Testbench for mux_8to1 (WIDTH = 8).
// A table of select sweeps with fixed expectations, hand-written reset and
// stall sequences, and a randomized stream checked against a queue model:
// every enabled edge appends D[Sel]; Y must show the entry LAT captures back.
module tb_mux_8to1;

`ifdef MUX8_1_INPUT_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;

   mux_8to1_if #(.WIDTH(8)) bus ();

   mux_8to1 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic [63:0] dPat;
      logic [7:0]  expY;
   } vec_t;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [7:0]  dv [8];
   logic [2:0]  selV;
   logic        enV;
   logic [7:0]  capQ [$];
   vec_t        vecs [16];
   logic [7:0]  firstVal;

   task automatic applyStimulus(input logic e, input logic [2:0] s, input logic [63:0] dPat);
      enV  = e;
      selV = s;
      for (int i = 0; i < 8; i++) begin
         dv[i] = dPat[i*8 +: 8];
      end
      bus.en  = e;
      bus.Sel = s;
      bus.D0  = dv[0];
      bus.D1  = dv[1];
      bus.D2  = dv[2];
      bus.D3  = dv[3];
      bus.D4  = dv[4];
      bus.D5  = dv[5];
      bus.D6  = dv[6];
      bus.D7  = dv[7];
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expY, input logic expV);
      checkCount++;
      if (bus.Y === expY && bus.y_valid === expV) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got Y=%h y_valid=%b, expected Y=%h y_valid=%b at %0t",
                  name, bus.Y, bus.y_valid, expY, expV, $time);
      end
   endtask

   task automatic modelCheck(input string name);
      if (capQ.size() >= LAT) begin
         checkOutput(name, capQ[capQ.size() - LAT], 1'b1);
      end else begin
         checkOutput(name, 8'h00, 1'b0);
      end
   endtask

   task automatic cycle(input string name);
      @(posedge clk);
      if (rst_n && enV) begin
         capQ.push_back(dv[selV]);
      end
      #1;
      modelCheck(name);
   endtask

   initial begin
      // Lane-bit sweep: D5 = 1, D7 = 1, everything else 0.
      for (int i = 0; i < 8; i++) begin
         vecs[i].sel  = 3'(i);
         vecs[i].dPat = 64'h0100_0100_0000_0000;
      end
      vecs[0].expY = 8'h00; vecs[1].expY = 8'h00; vecs[2].expY = 8'h00; vecs[3].expY = 8'h00;
      vecs[4].expY = 8'h00; vecs[5].expY = 8'h01; vecs[6].expY = 8'h00; vecs[7].expY = 8'h01;
      // Full-width sweep: Dn = 8'h10 + n.
      for (int i = 0; i < 8; i++) begin
         vecs[8 + i].sel  = 3'(i);
         vecs[8 + i].dPat = 64'h1716_1514_1312_1110;
      end
      vecs[8].expY  = 8'h10; vecs[9].expY  = 8'h11; vecs[10].expY = 8'h12; vecs[11].expY = 8'h13;
      vecs[12].expY = 8'h14; vecs[13].expY = 8'h15; vecs[14].expY = 8'h16; vecs[15].expY = 8'h17;

      // Power-up reset.
      applyStimulus(1'b0, 3'd0, 64'h0);
      rst_n = 1'b0;
      #2;
      checkOutput("reset_por", 8'h00, 1'b0);
      #10;
      rst_n = 1'b1;

      // Load a nonzero value so the async reset check below is meaningful.
      applyStimulus(1'b1, 3'd0, 64'h0000_0000_0000_00FF);
      for (int k = 0; k < LAT; k++) cycle("prime");
      checkOutput("prime_loaded", 8'hFF, 1'b1);

      // Asynchronous reset with no clock edge.
      applyStimulus(1'b1, 3'd1, 64'h0001_0001_0001_0001);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_async", 8'h00, 1'b0);
      capQ.delete();
      #3;
      rst_n = 1'b1;

      // Table-driven select sweeps.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, vecs[i].sel, vecs[i].dPat);
         cycle("sweep_model");
         if (i >= LAT - 1) checkOutput("sweep", vecs[i - LAT + 1].expY, 1'b1);
      end
      for (int k = 1; k < LAT; k++) begin
         cycle("sweep_tail_model");
         checkOutput("sweep_tail", vecs[16 - LAT + k].expY, 1'b1);
      end

      // Enable stall: capture lane 6 = 1, then hold 3 cycles with en low.
      applyStimulus(1'b1, 3'd6, 64'h0001_0000_0000_0000);
      for (int k = 0; k < LAT; k++) cycle("stall_load_model");
      checkOutput("stall_load", 8'h01, 1'b1);
      applyStimulus(1'b0, 3'd0, 64'h0);
      for (int k = 0; k < 3; k++) begin
         cycle("stall_hold_model");
         checkOutput("stall_hold", 8'h01, 1'b1);
      end
      applyStimulus(1'b1, 3'd0, 64'h0);
      for (int k = 0; k < LAT; k++) cycle("stall_resume_model");
      checkOutput("stall_resume", 8'h00, 1'b1);

      // Randomized stream with random stalls and one mid-stream reset.
      for (int i = 0; i < 200; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), {$urandom, $urandom});
         cycle("random");
         if (i == 100) begin
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput("midreset_async", 8'h00, 1'b0);
            capQ.delete();
            #4;
            rst_n = 1'b1;
            applyStimulus(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom});
            firstVal = dv[selV];
            for (int k = 1; k <= LAT; k++) begin
               cycle("post_reset_model");
               if (k < LAT) begin
                  checkOutput("post_reset_wait", 8'h00, 1'b0);
                  applyStimulus(1'b1, 3'($urandom_range(0, 7)), {$urandom, $urandom});
               end else begin
                  checkOutput("post_reset_first", firstVal, 1'b1);
               end
            end
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mux_8to1.md
# mux_8to1

Registered 8-to-1 multiplexer: one of eight data inputs is chosen by a 3-bit select and presented on a clocked output. It sits in datapath steering logic where a selected lane must be delivered glitch-free on a clock edge. The output carries a valid flag so downstream logic can tell reset or flushed state from real data.

## Interface
- WIDTH, 1, width of each data input and of Y
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; when low, all internal registers hold
- D0..D7  input  WIDTH each  data inputs; Dn is selected when Sel == n
- Sel  input  3  select code, 3'b000 selects D0 through 3'b111 selects D7
- Y  output  WIDTH  registered selected data
- y_valid  output  1  high when Y holds data captured from a sampled select

## Operation
- Selection function: Y_next = D[Sel], with Sel as unsigned 0..7. All eight codes are legal and there is no default or out-of-range case.
- Selection is purely combinational ahead of the output register. There is no priority logic and no one-hot decode requirement.
- On each rising clk with en = 1, the output register loads D[Sel] and y_valid loads 1.
- On each rising clk with en = 0:
  - Y and y_valid hold their values.
  - Any pipeline stage holds as well; nothing shifts.
- Reset (rst_n = 0, asynchronous, no clock needed):
  - Y = 0
  - y_valid = 0
  - every internal stage register = 0, including its valid bit
- Reset release: the first rising clk with rst_n = 1 and en = 1 starts normal capture.
- Data and Sel may change every cycle. Each captured value corresponds to the Sel/D pair sampled at that same edge; Sel is never paired with data from a different edge.
- Y never changes except at a rising clk edge or at reset assertion.

## Timing
- Latency without pipeline stage: 1 cycle from sampling edge to Y.
- Latency with pipeline stage: 2 cycles, and y_valid follows the same 2-cycle path.
- Throughput: one selection per enabled cycle.
- Reset assertion mid-stream discards all in-flight selections. y_valid stays 0 until a fresh capture completes the full latency after release.
- Reset assertion and a clock edge together: reset wins.
- Toggling en mid-stream stalls the pipe. No data is lost or duplicated, and the stage order is preserved.

## Configuration
- Macro: MUX8_1_INPUT_PIPE_EN.
- Defined:
  - an input register stage captures D0..D7 and Sel, plus a valid bit, when en = 1
  - the mux then selects from the registered copies into Y
  - latency is 2 cycles
  - both stages reset to 0
- Not defined:
  - the mux reads the live inputs directly into Y
  - latency is 1 cycle
- Port list and function are identical in both builds; only latency differs.

## Test plan
- Reset: assert rst_n = 0 with D0..D7 = 8'b1010_1010 and Sel = 3'b001. Required: Y = 0 and y_valid = 0 immediately, with no clock edge.
- Select sweep: set {D0..D7} = 8'b0000_0101 (D5 = 1, D7 = 1) and step Sel through 0..7 with en = 1. After the configured latency Y must read 0,0,0,0,0,1,0,1 in order, and y_valid = 1 throughout.
- Random data per cycle: change D0..D7 to new random bytes and Sel every cycle. Each Y must equal D[Sel] from the sampling edge exactly 1 cycle later (2 with MUX8_1_INPUT_PIPE_EN).
- Enable stall: capture Sel = 3'b110 with D6 = 1, then drop en for 3 cycles while Sel = 3'b000 and D0 = 0. Required: Y stays 1 and y_valid stays 1. Resuming en gives Y = 0 after the latency.
- Mid-stream reset: pulse rst_n low for half a cycle while selections are in flight. Required: Y = 0 and y_valid = 0 at once. The first valid output must appear the full latency after release, and carry post-reset data only.
- WIDTH = 8: set Dn = 8'h10 + n and sweep Sel. Required: Y reads 8'h10..8'h17.
